rv64g_l1_vlsu_miss_sched: RTL and testbench
===========================================

// Module: rv64g_l1_vlsu_miss_sched
// PURPOSE
//  Sequences the per-lane misses of one vector memory op (from VLSU hit detection) into line refill
//  requests to the MSHR, one outstanding at a time. Lowest-numbered pending lane issues first; other
//  lanes on the same 64B line can be merged into that request. When all lines are filled it hands one
//  replay mask back to the VLSU. Sits between VLSU hit detect and the L1 MSHR/refill path.
// PARAMETERS
//  NUM_LANES  8   VLSU lanes (lane index width 3 at default)
//  ADDR_W     64  lane address width
//  LINE_OFF_W 6   log2(line bytes); line address = addr[ADDR_W-1:LINE_OFF_W]
// PORTS
//  clk_i            in   1                  clock
//  rst_ni           in   1                  async active-low reset
//  flush_i          in   1                  pipeline kill
//  miss_valid_i     in   1                  op miss vector offered
//  miss_ready_o     out  1                  scheduler can accept (IDLE && !flush_i)
//  lane_miss_i      in   NUM_LANES          per-lane miss (= hit-detect lane_miss_o)
//  lane_addr_i      in   NUM_LANES*ADDR_W   per-lane byte address, lane l at [(l+1)*ADDR_W-1 -: ADDR_W]
//  op_store_i       in   1                  op is a store: request exclusive
//  req_valid_o      out  1                  refill request valid
//  req_ready_i      in   1                  MSHR accepts request
//  req_line_o       out  ADDR_W-LINE_OFF_W  line address of request
//  req_lane_mask_o  out  NUM_LANES          lanes covered by request
//  req_excl_o       out  1                  request M/E (registered op_store_i)
//  fill_valid_i     in   1                  1-cycle pulse: outstanding refill done
//  fill_err_i       in   1                  qualifies fill_valid_i: bus error
//  replay_valid_o   out  1                  replay available
//  replay_ready_i   in   1                  VLSU takes replay
//  replay_mask_o    out  NUM_LANES          lanes that missed (captured lane_miss_i)
//  replay_err_mask_o out NUM_LANES          lanes whose fill errored
//  busy_o           out  1                  state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; pending/cur/err masks, line and excl regs = 0. All outputs 0 except miss_ready_o=1.
//  - IDLE: on miss_valid_i&&miss_ready_o capture lane_miss_i->pending and miss_mask, addrs, op_store_i,
//    clear err_mask. Go to SEL, or straight to REPLAY if lane_miss_i==0 (zero-mask replay keeps handshake uniform).
//  - SEL (1 cycle): p = lowest set bit of pending. Register cur_line = line(addr[p]).
//    With merge, cur_mask = pending lanes whose line == cur_line; without merge, cur_mask = onehot(p). Go to REQ.
//  - REQ: req_valid_o=1; line/mask/excl held stable until req_ready_i. On handshake go to WAIT.
//  - WAIT: fill_valid_i: pending &= ~cur_mask; if fill_err_i then err_mask |= cur_mask.
//    Go to SEL if pending != 0 after update, else to REPLAY. fill_valid_i is ignored outside WAIT/DRAIN.
//  - REPLAY: replay_valid_o=1 with replay_mask_o=miss_mask and replay_err_mask_o=err_mask, held until
//    replay_ready_i, then IDLE. The masks are 0 whenever replay_valid_o=0.
//  - Latency: capture at T, req_valid_o at T+2. Fill at F gives replay_valid_o at F+1 (last line) or the
//    next req_valid_o at F+2.
//  - Flush: from IDLE/SEL/REQ/REPLAY go to IDLE next cycle; req_valid_o/replay_valid_o may drop without a
//    handshake because the downstream also flushes. From WAIT go to DRAIN (refill still in flight):
//    wait for fill_valid_i, then IDLE with no replay. flush_i in DRAIN has no extra effect.
//  - Simultaneous: flush_i with miss_valid_i in IDLE means no capture. fill_valid_i with flush_i in WAIT
//    means the fill is consumed and state goes to IDLE.
//  - Reset mid-op: async, so every register returns to its reset value immediately.
// CONFIGURATION
//  VLSU_MISS_MERGE_EN defined: same-line lanes merged into one request (at most one req per distinct line).
//  Undefined: one request per missing lane, req_lane_mask_o always onehot. All other behaviour identical.
// STRUCTURE
//  params.vh: LINE_OFF_W and the VLSU miss scheduler state encodings
//  (VMS_IDLE, VMS_SEL, VMS_REQ, VMS_WAIT, VMS_REPLAY, VMS_DRAIN), 3-bit.
//  Sub-module rv64g_l1_vlsu_miss_pick (combinational): pending mask + addrs -> lowest lane, line, match mask.
// TESTING
//  1 Lane 3 miss, addr 0x1000_0040 -> req line 0x400001, mask 0x08. Fill -> replay mask 0x08, err 0x00.
//  2 Lanes 0,2,5 @0x2000/0x2008/0x2030, lane 6 @0x3000 -> merge: reqs (0x80,0x25) then (0xC0,0x40).
//    No merge: 4 reqs, masks 0x01,0x04,0x20,0x40.
//  3 req_ready_i low 5 cycles in REQ -> req_valid_o/line/mask constant. Handshake on the 6th cycle -> WAIT.
//  4 Scenario 2 with fill_err_i on 2nd fill -> replay_mask_o 0x65, replay_err_mask_o 0x40.
//  5 flush_i in WAIT -> DRAIN, busy_o=1. Fill 3 cycles later -> IDLE, no replay_valid_o, miss_ready_o=1.
//  6 lane_miss_i=0 captured -> replay_valid_o at T+1, mask 0, no req. rst_ni low in REQ -> all outputs reset.

Source files
------------

// File: rtl/rv64g_l1_vlsu_miss_sched_pkg.sv
// Shared types for the VLSU miss scheduler: FSM state encoding and line geometry.
package rv64g_l1_vlsu_miss_sched_pkg;

    localparam int VMS_LINE_OFF_W = 6;

    typedef enum logic [2:0] {
        VMS_IDLE   = 3'd0,
        VMS_SEL    = 3'd1,
        VMS_REQ    = 3'd2,
        VMS_WAIT   = 3'd3,
        VMS_REPLAY = 3'd4,
        VMS_DRAIN  = 3'd5
    } vms_state_e;

endpackage

// File: rtl/rv64g_l1_vlsu_miss_sched_if.sv
// Miss/request/fill/replay channels between VLSU hit detect, the miss scheduler and the L1 MSHR.
interface rv64g_l1_vlsu_miss_sched_if
    import rv64g_l1_vlsu_miss_sched_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int ADDR_W     = 64,
    parameter int LINE_OFF_W = VMS_LINE_OFF_W
);
    logic                           flush_i;
    logic                           miss_valid_i;
    logic                           miss_ready_o;
    logic [NUM_LANES-1:0]           lane_miss_i;
    logic [NUM_LANES*ADDR_W-1:0]    lane_addr_i;
    logic                           op_store_i;
    logic                           req_valid_o;
    logic                           req_ready_i;
    logic [ADDR_W-LINE_OFF_W-1:0]   req_line_o;
    logic [NUM_LANES-1:0]           req_lane_mask_o;
    logic                           req_excl_o;
    logic                           fill_valid_i;
    logic                           fill_err_i;
    logic                           replay_valid_o;
    logic                           replay_ready_i;
    logic [NUM_LANES-1:0]           replay_mask_o;
    logic [NUM_LANES-1:0]           replay_err_mask_o;
    logic                           busy_o;

    // Scheduler side
    modport slave (
        input  flush_i, miss_valid_i, lane_miss_i, lane_addr_i, op_store_i,
               req_ready_i, fill_valid_i, fill_err_i, replay_ready_i,
        output miss_ready_o, req_valid_o, req_line_o, req_lane_mask_o, req_excl_o,
               replay_valid_o, replay_mask_o, replay_err_mask_o, busy_o
    );

    // VLSU / MSHR side
    modport master (
        output flush_i, miss_valid_i, lane_miss_i, lane_addr_i, op_store_i,
               req_ready_i, fill_valid_i, fill_err_i, replay_ready_i,
        input  miss_ready_o, req_valid_o, req_line_o, req_lane_mask_o, req_excl_o,
               replay_valid_o, replay_mask_o, replay_err_mask_o, busy_o
    );

endinterface

// File: rtl/rv64g_l1_vlsu_miss_sched_pick.sv
// Picks the lowest pending lane, its line address and the lanes covered by that line's request.
// VLSU_MISS_MERGE_EN: cover every pending lane on the same line; otherwise only the picked lane.
module rv64g_l1_vlsu_miss_pick #(
    parameter int NUM_LANES = 8,
    parameter int LINE_W    = 58
) (
    input  logic [NUM_LANES-1:0]        pending,
    input  logic [NUM_LANES*LINE_W-1:0] lines,
    output logic [LINE_W-1:0]           line,
    output logic [NUM_LANES-1:0]        match_mask
);

    logic [NUM_LANES-1:0] first_oh;

    // Two's-complement trick isolates the lowest set bit
    assign first_oh = pending & (~pending + NUM_LANES'(1));

    always_comb begin
        line = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (first_oh[l]) begin
                line = lines[l*LINE_W +: LINE_W];
            end
        end
    end

`ifdef VLSU_MISS_MERGE_EN
    always_comb begin
        match_mask = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            match_mask[l] = pending[l] && (lines[l*LINE_W +: LINE_W] == line);
        end
    end
`else
    assign match_mask = first_oh;
`endif

endmodule

// File: rtl/rv64g_l1_vlsu_miss_sched.sv
// Sequences one vector op's lane misses into line refills (one outstanding) and returns a replay mask.
// Build option VLSU_MISS_MERGE_EN merges same-line lanes into a single refill request.
module rv64g_l1_vlsu_miss_sched
    import rv64g_l1_vlsu_miss_sched_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int ADDR_W     = 64,
    parameter int LINE_OFF_W = VMS_LINE_OFF_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    rv64g_l1_vlsu_miss_sched_if.slave bus
);

    localparam int LINE_W = ADDR_W - LINE_OFF_W;

    vms_state_e                  state;
    logic [NUM_LANES-1:0]        pending;
    logic [NUM_LANES-1:0]        miss_mask;
    logic [NUM_LANES-1:0]        err_mask;
    logic [NUM_LANES-1:0]        cur_mask;
    logic [LINE_W-1:0]           cur_line;
    logic [NUM_LANES*LINE_W-1:0] line_q;
    logic                        excl_q;
    logic                        req_valid_q;
    logic                        replay_valid_q;

    logic [NUM_LANES*LINE_W-1:0] line_in;
    logic [LINE_W-1:0]           pick_line;
    logic [NUM_LANES-1:0]        pick_mask;
    logic [NUM_LANES-1:0]        pending_nxt;

    // Only line addresses matter after capture; byte offsets are dropped here
    always_comb begin
        line_in = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            line_in[l*LINE_W +: LINE_W] = bus.lane_addr_i[l*ADDR_W + LINE_OFF_W +: LINE_W];
        end
    end

    rv64g_l1_vlsu_miss_pick #(
        .NUM_LANES (NUM_LANES),
        .LINE_W    (LINE_W)
    ) u_pick (
        .pending    (pending),
        .lines      (line_q),
        .line       (pick_line),
        .match_mask (pick_mask)
    );

    assign pending_nxt = pending & ~cur_mask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= VMS_IDLE;
            pending        <= '0;
            miss_mask      <= '0;
            err_mask       <= '0;
            cur_mask       <= '0;
            cur_line       <= '0;
            line_q         <= '0;
            excl_q         <= 1'b0;
            req_valid_q    <= 1'b0;
            replay_valid_q <= 1'b0;
        end else begin
            case (state)
                VMS_IDLE: begin
                    if (bus.miss_valid_i && !bus.flush_i) begin
                        pending   <= bus.lane_miss_i;
                        miss_mask <= bus.lane_miss_i;
                        line_q    <= line_in;
                        excl_q    <= bus.op_store_i;
                        err_mask  <= '0;
                        if (bus.lane_miss_i == '0) begin
                            state          <= VMS_REPLAY;
                            replay_valid_q <= 1'b1;
                        end else begin
                            state <= VMS_SEL;
                        end
                    end
                end
                VMS_SEL: begin
                    if (bus.flush_i) begin
                        state <= VMS_IDLE;
                    end else begin
                        cur_line    <= pick_line;
                        cur_mask    <= pick_mask;
                        req_valid_q <= 1'b1;
                        state       <= VMS_REQ;
                    end
                end
                VMS_REQ: begin
                    // Flush wins over a same-cycle handshake: the MSHR is flushed too
                    if (bus.flush_i) begin
                        req_valid_q <= 1'b0;
                        state       <= VMS_IDLE;
                    end else if (bus.req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state       <= VMS_WAIT;
                    end
                end
                VMS_WAIT: begin
                    if (bus.fill_valid_i) begin
                        pending <= pending_nxt;
                        if (bus.fill_err_i) begin
                            err_mask <= err_mask | cur_mask;
                        end
                        if (bus.flush_i) begin
                            state <= VMS_IDLE;
                        end else if (pending_nxt == '0) begin
                            state          <= VMS_REPLAY;
                            replay_valid_q <= 1'b1;
                        end else begin
                            state <= VMS_SEL;
                        end
                    end else if (bus.flush_i) begin
                        state <= VMS_DRAIN;
                    end
                end
                VMS_REPLAY: begin
                    if (bus.flush_i || bus.replay_ready_i) begin
                        replay_valid_q <= 1'b0;
                        state          <= VMS_IDLE;
                    end
                end
                VMS_DRAIN: begin
                    if (bus.fill_valid_i) begin
                        state <= VMS_IDLE;
                    end
                end
                default: begin
                    state          <= VMS_IDLE;
                    req_valid_q    <= 1'b0;
                    replay_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miss_ready_o      = (state == VMS_IDLE) && !bus.flush_i;
    assign bus.busy_o            = (state != VMS_IDLE);
    assign bus.req_valid_o       = req_valid_q;
    assign bus.req_line_o        = cur_line;
    assign bus.req_lane_mask_o   = cur_mask;
    assign bus.req_excl_o        = excl_q;
    assign bus.replay_valid_o    = replay_valid_q;
    assign bus.replay_mask_o     = replay_valid_q ? miss_mask : '0;
    assign bus.replay_err_mask_o = replay_valid_q ? err_mask : '0;

endmodule

// File: tb/tb_rv64g_l1_vlsu_miss_sched.sv
// Randomized self-checking bench for rv64g_l1_vlsu_miss_sched against a request-list reference model.
module tb_rv64g_l1_vlsu_miss_sched;

    localparam int NL = 8;
    localparam int AW = 64;
    localparam int LO = 6;
    localparam int LW = AW - LO;

    typedef struct {
        logic [LW-1:0] line;
        logic [NL-1:0] mask;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv64g_l1_vlsu_miss_sched_if #(.NUM_LANES(NL), .ADDR_W(AW), .LINE_OFF_W(LO)) bus ();

    rv64g_l1_vlsu_miss_sched #(.NUM_LANES(NL), .ADDR_W(AW), .LINE_OFF_W(LO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0] op_addr [NL];
    req_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected refill requests: lowest pending lane first, same-line lanes folded in when merging
    task automatic build_model(input logic [NL-1:0] miss);
        logic [NL-1:0] pend;
        req_t r;
        exp_q.delete();
        pend = miss;
        while (pend != '0) begin
            int p;
            p = 0;
            while (!pend[p]) p++;
            r.line = op_addr[p] >> LO;
`ifdef VLSU_MISS_MERGE_EN
            r.mask = '0;
            for (int l = 0; l < NL; l++)
                if (pend[l] && ((op_addr[l] >> LO) == AW'(r.line))) r.mask[l] = 1'b1;
`else
            r.mask = NL'(1) << p;
`endif
            exp_q.push_back(r);
            pend = pend & ~r.mask;
        end
    endtask

    task automatic drive_idle();
        bus.flush_i = 0; bus.miss_valid_i = 0; bus.lane_miss_i = '0; bus.lane_addr_i = '0;
        bus.op_store_i = 0; bus.req_ready_i = 0; bus.fill_valid_i = 0; bus.fill_err_i = 0;
        bus.replay_ready_i = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"}, bus.miss_ready_o, 1);
        check({tag, "_req_valid"}, bus.req_valid_o, 0);
        check({tag, "_req_line"}, bus.req_line_o, 0);
        check({tag, "_req_mask"}, bus.req_lane_mask_o, 0);
        check({tag, "_req_excl"}, bus.req_excl_o, 0);
        check({tag, "_replay_valid"}, bus.replay_valid_o, 0);
        check({tag, "_replay_mask"}, bus.replay_mask_o, 0);
        check({tag, "_replay_err"}, bus.replay_err_mask_o, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
    endtask

    // Offers one op at a negedge; returns at the following negedge (capture cycle + 1)
    task automatic start_op(input logic [NL-1:0] miss, input bit store);
        bus.miss_valid_i = 1; bus.lane_miss_i = miss; bus.op_store_i = store;
        for (int l = 0; l < NL; l++) bus.lane_addr_i[l*AW +: AW] = op_addr[l];
        @(negedge clk);
        bus.miss_valid_i = 0; bus.lane_miss_i = NL'($urandom); bus.op_store_i = 1'($urandom);
        for (int l = 0; l < NL; l++) bus.lane_addr_i[l*AW +: AW] = {$urandom, $urandom};
    endtask

    task automatic run_op(input logic [NL-1:0] miss, input bit store, input logic [31:0] err_sel,
                          input int stall, output logic [63:0] first_line, output logic [63:0] first_mask,
                          output logic [63:0] rmask, output logic [63:0] emask);
        logic [NL-1:0] exp_err;
        int st;
        int w;
        exp_err = '0; first_line = 0; first_mask = 0;
        build_model(miss);
        if ($urandom_range(0, 3) == 0) begin
            bus.fill_valid_i = 1; bus.fill_err_i = 1;
            @(negedge clk);
            bus.fill_valid_i = 0; bus.fill_err_i = 0;
            check("idle_stray_fill_busy", bus.busy_o, 0);
        end
        check("miss_ready_idle", bus.miss_ready_o, 1);
        start_op(miss, store);
        check("busy_after_capture", bus.busy_o, 1);
        check("miss_ready_when_busy", bus.miss_ready_o, 0);
        check("no_req_at_t1", bus.req_valid_o, 0);
        if (exp_q.size() != 0) @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) begin first_line = 64'(bus.req_line_o); first_mask = 64'(bus.req_lane_mask_o); end
            st = (stall < 0) ? $urandom_range(0, 3) : stall;
            for (int s = 0; s <= st; s++) begin
                check("req_valid", bus.req_valid_o, 1);
                check("req_line", bus.req_line_o, exp_q[k].line);
                check("req_mask", bus.req_lane_mask_o, exp_q[k].mask);
                check("req_excl", bus.req_excl_o, store);
                check("req_no_replay", bus.replay_valid_o, 0);
                if (s == st) bus.req_ready_i = 1;
                else bus.fill_valid_i = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                bus.req_ready_i = 0; bus.fill_valid_i = 0;
            end
            w = $urandom_range(0, 3);
            for (int s = 0; s <= w; s++) begin
                check("wait_no_req", bus.req_valid_o, 0);
                check("wait_no_replay", bus.replay_valid_o, 0);
                check("wait_busy", bus.busy_o, 1);
                if (s < w) @(negedge clk);
            end
            bus.fill_valid_i = 1; bus.fill_err_i = err_sel[k];
            if (err_sel[k]) exp_err |= exp_q[k].mask;
            @(negedge clk);
            bus.fill_valid_i = 0; bus.fill_err_i = 1'($urandom);
            if (k != exp_q.size() - 1) begin
                check("sel_after_fill_no_req", bus.req_valid_o, 0);
                check("sel_after_fill_no_replay", bus.replay_valid_o, 0);
                @(negedge clk);
            end
        end
        bus.fill_err_i = 0;
        rmask = 64'(bus.replay_mask_o); emask = 64'(bus.replay_err_mask_o);
        st = $urandom_range(0, 2);
        for (int s = 0; s <= st; s++) begin
            check("replay_valid", bus.replay_valid_o, 1);
            check("replay_mask", bus.replay_mask_o, miss);
            check("replay_err_mask", bus.replay_err_mask_o, exp_err);
            check("replay_no_req", bus.req_valid_o, 0);
            bus.replay_ready_i = (s == st);
            @(negedge clk);
        end
        bus.replay_ready_i = 0;
        check("after_replay_valid", bus.replay_valid_o, 0);
        check("after_replay_mask_zero", bus.replay_mask_o, 0);
        check("after_replay_err_zero", bus.replay_err_mask_o, 0);
        check("after_replay_busy", bus.busy_o, 0);
        check("after_replay_miss_ready", bus.miss_ready_o, 1);
    endtask

    task automatic set_scn2();
        for (int l = 0; l < NL; l++) op_addr[l] = {$urandom, $urandom};
        op_addr[0] = 64'h2000; op_addr[2] = 64'h2008; op_addr[5] = 64'h2030; op_addr[6] = 64'h3000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fl, fm, rm, em;
        logic [LW-1:0] pool [4];
        drive_idle();
        for (int l = 0; l < NL; l++) op_addr[l] = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Single lane miss, also exercising a 5-cycle request stall
        for (int l = 0; l < NL; l++) op_addr[l] = {$urandom, $urandom};
        op_addr[3] = 64'h1000_0040;
        run_op(8'h08, 1'b0, 32'h0, 5, fl, fm, rm, em);
        check("scn1_line", fl, 64'h40_0001);
        check("scn1_mask", fm, 64'h08);
        check("scn1_replay_mask", rm, 64'h08);
        check("scn1_replay_err", em, 64'h00);

        set_scn2();
        run_op(8'h65, 1'b1, 32'h0, -1, fl, fm, rm, em);
        check("scn2_first_line", fl, 64'h80);
`ifdef VLSU_MISS_MERGE_EN
        check("scn2_first_mask", fm, 64'h25);
`else
        check("scn2_first_mask", fm, 64'h01);
`endif

        set_scn2();
        run_op(8'h65, 1'b0, 32'h2, -1, fl, fm, rm, em);
        check("scn4_replay_mask", rm, 64'h65);
`ifdef VLSU_MISS_MERGE_EN
        check("scn4_replay_err", em, 64'h40);
`else
        check("scn4_replay_err", em, 64'h04);
`endif

        // Zero-mask op: replay at capture+1, no request
        run_op(8'h00, 1'b0, 32'h0, -1, fl, fm, rm, em);
        check("scn6_replay_mask", rm, 64'h0);

        // Flush in WAIT: drain the in-flight refill, then idle with no replay
        for (int l = 0; l < NL; l++) op_addr[l] = {$urandom, $urandom};
        start_op(8'h10, 1'b0);
        @(negedge clk);
        bus.req_ready_i = 1;
        @(negedge clk);
        bus.req_ready_i = 0; bus.flush_i = 1;
        @(negedge clk);
        bus.flush_i = 0;
        check("drain_busy", bus.busy_o, 1);
        check("drain_miss_ready", bus.miss_ready_o, 0);
        check("drain_no_req", bus.req_valid_o, 0);
        @(negedge clk);
        bus.flush_i = 1;
        @(negedge clk);
        bus.flush_i = 0;
        check("drain_flush_no_effect", bus.busy_o, 1);
        bus.fill_valid_i = 1; bus.fill_err_i = 1;
        @(negedge clk);
        bus.fill_valid_i = 0; bus.fill_err_i = 0;
        check("drain_done_busy", bus.busy_o, 0);
        check("drain_done_miss_ready", bus.miss_ready_o, 1);
        check("drain_done_no_replay", bus.replay_valid_o, 0);
        @(negedge clk);
        check("drain_done_no_replay_late", bus.replay_valid_o, 0);

        // Fill together with flush in WAIT
        start_op(8'h03, 1'b0);
        @(negedge clk);
        bus.req_ready_i = 1;
        @(negedge clk);
        bus.req_ready_i = 0; bus.flush_i = 1; bus.fill_valid_i = 1;
        @(negedge clk);
        bus.flush_i = 0; bus.fill_valid_i = 0;
        check("fill_flush_busy", bus.busy_o, 0);
        check("fill_flush_no_replay", bus.replay_valid_o, 0);
        check("fill_flush_no_req", bus.req_valid_o, 0);

        // Flush in SEL, REQ and REPLAY
        start_op(8'h80, 1'b0);
        bus.flush_i = 1;
        @(negedge clk);
        bus.flush_i = 0;
        check("flush_sel_busy", bus.busy_o, 0);
        check("flush_sel_no_req", bus.req_valid_o, 0);
        start_op(8'h80, 1'b0);
        @(negedge clk);
        check("flush_req_pre_valid", bus.req_valid_o, 1);
        bus.flush_i = 1;
        @(negedge clk);
        bus.flush_i = 0;
        check("flush_req_valid", bus.req_valid_o, 0);
        check("flush_req_busy", bus.busy_o, 0);
        start_op(8'h00, 1'b0);
        check("flush_replay_pre_valid", bus.replay_valid_o, 1);
        bus.flush_i = 1;
        #1;
        check("flush_replay_miss_ready", bus.miss_ready_o, 0);
        @(negedge clk);
        bus.flush_i = 0;
        check("flush_replay_valid", bus.replay_valid_o, 0);
        check("flush_replay_busy", bus.busy_o, 0);

        // Flush with miss_valid in IDLE: no capture
        bus.flush_i = 1; bus.miss_valid_i = 1; bus.lane_miss_i = 8'hFF;
        #1;
        check("flush_idle_miss_ready", bus.miss_ready_o, 0);
        @(negedge clk);
        drive_idle();
        check("flush_idle_no_capture", bus.busy_o, 0);

        // Asynchronous reset while a request is presented
        start_op(8'h04, 1'b1);
        @(negedge clk);
        check("rst_req_pre_valid", bus.req_valid_o, 1);
        rst_n = 0;
        #1;
        check_reset_outputs("rst_in_req");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_reset_outputs("rst_release");

        for (int n = 0; n < 150; n++) begin
            logic [NL-1:0] miss;
            for (int i = 0; i < 4; i++) pool[i] = LW'({$urandom, $urandom});
            for (int l = 0; l < NL; l++) op_addr[l] = {pool[$urandom_range(0, 3)], 6'($urandom)};
            miss = ($urandom_range(0, 9) == 0) ? '0 : NL'($urandom);
            run_op(miss, 1'($urandom), $urandom, -1, fl, fm, rm, em);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
